// File: rtl/gfx_pkg.sv
// Shared graphics definitions: default pixel format, colour key and fade state encoding.
package gfx_pkg;

  localparam int          DEF_N_LAYERS    = 4;
  localparam int          DEF_RGB_W       = 12;
  localparam logic [11:0] DEF_KEY_RGB     = 12'h0F0;
  localparam int          DEF_FRAMES_STEP = 2;

  // Full brightness level; the fade multiplier is level/16.
  localparam logic [4:0]  FADE_FULL       = 5'd16;

  typedef enum logic [1:0] {
    BRIGHT,
    FADE_OUT,
    DARK,
    FADE_IN
  } fade_state_e;

endpackage

// File: rtl/fade_ctrl.sv
// Frame-synchronous fade engine: walks the brightness level between 0 and 16,
// one step every FRAMES_STEP frame_start pulses, with mid-fade reversal.
module fade_ctrl
  import gfx_pkg::*;
#(
  parameter int FRAMES_STEP = DEF_FRAMES_STEP
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       fade_out,
  input  logic       fade_in,
  output logic [4:0] fade_level,
  output logic       fade_busy,
  output logic       fade_done
);

  localparam int CNT_W = (FRAMES_STEP > 1) ? $clog2(FRAMES_STEP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_STEP - 1);

  fade_state_e      state_q, state_d;
  logic [4:0]       level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  // State, level, frame counter and done pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BRIGHT;
      level_q <= FADE_FULL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; fade_out beats fade_in, and a reversal takes priority over a frame step.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      BRIGHT: begin
        if (fade_out) begin
          state_d = FADE_OUT;
          cnt_d   = '0;
        end
      end
      DARK: begin
        if (!fade_out && fade_in) begin
          state_d = FADE_IN;
          cnt_d   = '0;
        end
      end
      FADE_OUT: begin
        if (!fade_out && fade_in) begin
          cnt_d = '0;
          if (level_q == FADE_FULL) begin
            state_d = BRIGHT;
            done_d  = 1'b1;
          end else begin
            state_d = FADE_IN;
          end
        end else if (frame_start) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = level_q - 5'd1;
            if (level_q == 5'd1) begin
              state_d = DARK;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FADE_IN: begin
        if (fade_out) begin
          cnt_d = '0;
          if (level_q == 5'd0) begin
            state_d = DARK;
            done_d  = 1'b1;
          end else begin
            state_d = FADE_OUT;
          end
        end else if (frame_start) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = level_q + 5'd1;
            if (level_q == FADE_FULL - 5'd1) begin
              state_d = BRIGHT;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = BRIGHT;
        level_d = FADE_FULL;
        cnt_d   = '0;
      end
    endcase
  end

  assign fade_level = level_q;
  assign fade_busy  = (state_q == FADE_OUT) || (state_q == FADE_IN);
  assign fade_done  = done_q;

endmodule

// File: rtl/layer_compositor.sv
// N-layer pixel compositor: priority select with colour-key transparency,
// then per-channel brightness scaling from the fade engine. Two-cycle latency.
module layer_compositor
  import gfx_pkg::*;
#(
  parameter int               N_LAYERS    = DEF_N_LAYERS,
  parameter int               RGB_W       = DEF_RGB_W,
  parameter logic [RGB_W-1:0] KEY_RGB     = RGB_W'(DEF_KEY_RGB),
  parameter int               FRAMES_STEP = DEF_FRAMES_STEP
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      video_off,
  input  logic [N_LAYERS*RGB_W-1:0] layer_rgb,
  input  logic [N_LAYERS-1:0]       layer_on,
  input  logic [N_LAYERS-1:0]       layer_en,
  input  logic [RGB_W-1:0]          bg_rgb,
  input  logic                      fade_out,
  input  logic                      fade_in,
  output logic [RGB_W-1:0]          rgb_out,
  output logic [4:0]                fade_level,
  output logic                      fade_busy,
  output logic                      fade_done
);

  localparam int CH_W = RGB_W / 3;

  logic [N_LAYERS-1:0] hit;
  logic [RGB_W-1:0]    pix_q, pix_d;
  logic [RGB_W-1:0]    rgb_out_q, rgb_out_d;
  logic [CH_W+4:0]     prod;

  fade_ctrl #(
    .FRAMES_STEP(FRAMES_STEP)
  ) u_fade_ctrl (
    .clk        (clk),
    .reset      (reset),
    .frame_start(frame_start),
    .fade_out   (fade_out),
    .fade_in    (fade_in),
    .fade_level (fade_level),
    .fade_busy  (fade_busy),
    .fade_done  (fade_done)
  );

  // A layer competes only when it covers the pixel, is enabled and is not the key colour.
  for (genvar i = 0; i < N_LAYERS; i++) begin : g_hit
    assign hit[i] = layer_on[i] & layer_en[i] &
                    (layer_rgb[i*RGB_W +: RGB_W] != KEY_RGB);
  end

  // Priority select: scan from the lowest priority up so the lowest index wins.
  always_comb begin
    pix_d = bg_rgb;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) pix_d = layer_rgb[i*RGB_W +: RGB_W];
    end
    if (video_off) pix_d = '0;
  end

  // Brightness scaling: each channel times level/16, so level 16 is an exact pass-through.
  always_comb begin
    prod      = '0;
    rgb_out_d = '0;
    for (int c = 0; c < 3; c++) begin
      prod = {5'b0, pix_q[c*CH_W +: CH_W]} * {{CH_W{1'b0}}, fade_level};
      rgb_out_d[c*CH_W +: CH_W] = CH_W'(prod >> 4);
    end
  end

  // Two pipeline stages: selected pixel, then scaled output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_q     <= '0;
      rgb_out_q <= '0;
    end else begin
      pix_q     <= pix_d;
      rgb_out_q <= rgb_out_d;
    end
  end

  assign rgb_out = rgb_out_q;

endmodule
